// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline instruction-fetch stage.
//   PCSRC_*        : pcsource encodings driven by the decode stage
//   NOP            : instruction word placed in the IF/ID register on a bubble
//   *_DEF          : default values for the fetch-stage parameters
//   fetch_ent_t    : one prefetch-queue entry {PC+4, instruction}
//   word_align()   : clears the byte-offset bits of an address
package pl_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          QDEPTH_DEF    = 4;
  localparam int          MAX_OUTST_DEF = 2;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_ent_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pl_fifo.sv
// Prefetch queue: DEPTH x W synchronous FIFO with flush.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset (empties the queue)
//   flush_i  : discard all entries (same effect as reset on pointers)
//   push_i   : write data_i at the tail
//   pop_i    : drop the head entry
//   data_i   : write data
//   data_o   : head entry (valid when !empty_o)
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
//   count_o  : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module pl_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // A push into a full queue is only accepted when the head leaves in the
  // same cycle, so simultaneous push/pop works at every occupancy.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/pl_if_fetch.sv
// Instruction-fetch stage with prefetch queue and IF/ID register.
//   clk                 : clock, all state on the rising edge
//   clrn                : synchronous active-low reset
//   pcsource            : next-PC select from ID (seq / branch / reg jump / jump)
//   bpc, rpc, jpc       : redirect targets from ID
//   nostall             : ID advances this cycle
//   imem_req/imem_addr  : fetch request and word-aligned address
//   imem_gnt            : request accepted this cycle
//   imem_rvalid/rdata   : in-order instruction response
//   inst, dpc4, dvalid  : IF/ID register (instruction, its PC+4, real-instruction flag)
// Fetch runs ahead of ID into a small queue; a taken redirect flushes the
// queue, retargets the fetch PC and drops responses still in flight.
module pl_if_fetch
  import pl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          QDEPTH    = QDEPTH_DEF,
  parameter int          MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;   // PC of the next response that will be kept
  logic [OW-1:0] outst_q, outst_d;     // granted, not yet answered (kept or dropped)
  logic [OW-1:0] disc_q, disc_d;       // in-flight responses still to be dropped
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   dpc4_q, dpc4_d;
  logic          dvalid_q, dvalid_d;

  logic          redir, grant, rsp, push, pop;
  logic          room, outst_ok;
  logic [31:0]   target, occ_sum;
  fetch_ent_t    head, wr_ent;
  logic          q_empty, q_full;
  logic [CW-1:0] q_cnt;

  always_comb begin
    target = bpc;
    case (pcsource)
      PCSRC_JR: target = rpc;
      PCSRC_J:  target = jpc;
      default:  target = bpc;
    endcase
  end

  // pcsource only matters for a real instruction that ID is consuming.
  assign redir = dvalid_q && nostall && (pcsource != PCSRC_SEQ);

  // Every outstanding request reserves a queue slot, so pushes never
  // find the queue full. Dropped responses still hold their reservation
  // until they arrive, which keeps the accounting in one counter.
  assign occ_sum  = 32'(q_cnt) + 32'(outst_q);
  assign room     = occ_sum < 32'(QDEPTH);
  assign outst_ok = 32'(outst_q) < 32'(MAX_OUTST);

  assign imem_req  = clrn && room && outst_ok && !q_full && !redir;
  assign imem_addr = fpc_q;
  assign grant     = imem_req && imem_gnt;

  // A response with nothing outstanding cannot belong to us (e.g. a
  // request from before reset); ignoring it keeps the counter sane.
  assign rsp  = imem_rvalid && (outst_q != '0);
  assign push = rsp && !redir && (disc_q == '0);
  assign pop  = nostall && !q_empty && !redir;

  assign wr_ent.pc4  = rsp_pc_q + 32'd4;
  assign wr_ent.inst = imem_rdata;

  pl_fifo #(
    .DEPTH (QDEPTH),
    .W     (64)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (clrn),
    .flush_i (redir),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_ent),
    .data_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_cnt)
  );

  always_comb begin
    fpc_d    = fpc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q + OW'(grant) - OW'(rsp);
    disc_d   = disc_q;
    inst_d   = inst_q;
    dpc4_d   = dpc4_q;
    dvalid_d = dvalid_q;
    if (redir) begin
      // Everything still in flight after this cycle is stale; a response
      // arriving right now is dropped as well and so not counted.
      fpc_d    = word_align(target);
      rsp_pc_d = word_align(target);
      disc_d   = outst_q - OW'(rsp);
      inst_d   = NOP;
      dvalid_d = 1'b0;
    end else begin
      if (grant) fpc_d = fpc_q + 32'd4;
      if (push)  rsp_pc_d = rsp_pc_q + 32'd4;
      if (rsp && (disc_q != '0)) disc_d = disc_q - OW'(1);
      if (nostall) begin
        if (!q_empty) begin
          inst_d   = head.inst;
          dpc4_d   = head.pc4;
          dvalid_d = 1'b1;
        end else begin
          inst_d   = NOP;
          dvalid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      fpc_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      disc_q   <= '0;
      inst_q   <= NOP;
      dpc4_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      inst_q   <= inst_d;
      dpc4_q   <= dpc4_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign inst   = inst_q;
  assign dpc4   = dpc4_q;
  assign dvalid = dvalid_q;

endmodule

// File: tb/tb_pl_if_fetch.sv
module tb_pl_if_fetch;
  import pl_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, rpc;
  logic        nostall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst, dpc4;
  logic        dvalid;

  always #5 clk = ~clk;

  pl_if_fetch #(
    .RESET_PC  (32'h0000_0000),
    .QDEPTH    (4),
    .MAX_OUTST (2)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .jpc         (jpc),
    .rpc         (rpc),
    .nostall     (nostall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .dpc4        (dpc4),
    .dvalid      (dvalid)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // memory model: granted requests waiting for their response cycle
  logic [31:0] p_addr[$];
  int          p_due[$];
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1;
  bit          rnd_gnt = 0;
  logic [31:0] gaddr[$];
  int          max_out = 0;

  // expected IF/ID stream
  logic [31:0] exp_pc4;
  int          accepted = 0;

  logic        s_req;
  logic [31:0] s_addr;
  bit          chk_stable = 0;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory response, sample the request,
  // advance the clock and check the IF/ID register against the stream.
  task automatic tick();
    bit          redir_now, rs, ns;
    logic [31:0] h_inst, h_pc;
    logic        h_v;
    int          lat, due;
    if (p_due.size() > max_out) max_out = p_due.size();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (p_due.size() > 0 && p_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mdata(p_addr[0]);
      void'(p_due.pop_front());
      void'(p_addr.pop_front());
    end
    if (rnd_gnt) imem_gnt = ($urandom_range(0, 2) != 0);
    #1;
    redir_now = clrn && nostall && dvalid && (pcsource != PCSRC_SEQ);
    if (chk_stable && clrn && !redir_now) begin
      chk("req_held", imem_req, 1);
      chk("addr_held", imem_addr, prev_addr);
    end
    s_req  = imem_req;
    s_addr = imem_addr;
    if (imem_req && imem_gnt) begin
      gaddr.push_back(imem_addr);
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      p_due.push_back(due);
      p_addr.push_back(imem_addr);
    end
    chk_stable = imem_req && !imem_gnt && !redir_now && clrn;
    prev_addr  = imem_addr;
    h_inst = inst; h_pc = dpc4; h_v = dvalid;
    rs = clrn; ns = nostall;
    @(posedge clk);
    #1;
    cyc++;
    if (rs && ns && dvalid) begin
      chk("id_pc4", dpc4, exp_pc4);
      chk("id_inst", inst, mdata(exp_pc4 - 32'd4));
      exp_pc4 = exp_pc4 + 32'd4;
      accepted++;
    end else if (rs && !ns) begin
      chk("hold_inst", inst, h_inst);
      chk("hold_pc4", dpc4, h_pc);
      chk("hold_v", dvalid, h_v);
    end
  endtask

  task automatic start_reset();
    clrn = 1'b0;
    p_due.delete();
    p_addr.delete();
    gaddr.delete();
    chk_stable = 0;
    last_due = cyc;
    exp_pc4 = 32'h4;
  endtask

  task automatic wait_dvalid(input string tag);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (dvalid) found = 1;
      else tick();
    end
    chk(tag, found, 1);
  endtask

  task automatic wait_pc4(input string tag, input logic [31:0] pc4);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dvalid && dpc4 == pc4) found = 1;
      else tick();
    end
    chk(tag, found, 1);
  endtask

  task automatic wait_grant(input string tag, input int idx, input logic [31:0] addr);
    for (int i = 0; i < 20 && gaddr.size() <= idx; i++) tick();
    chk(tag, (gaddr.size() > idx) ? gaddr[idx] : 32'hDEAD_BEEF, addr);
  endtask

  initial begin
    int ng, acc0;
    clrn = 1'b0; nostall = 1'b1; pcsource = PCSRC_SEQ;
    bpc = '0; jpc = '0; rpc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    start_reset();

    // reset state
    tick();
    chk("rst_req", s_req, 0);
    tick();
    chk("rst_dvalid", dvalid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_dpc4", dpc4, 32'h0);

    // sequential fetch, 1-cycle latency; pcsource ignored while dvalid=0
    clrn = 1'b1;
    pcsource = PCSRC_BR; bpc = 32'h500;
    tick();
    tick();
    chk("startup_v", dvalid, 0);
    tick();
    pcsource = PCSRC_SEQ;
    chk("grant0", gaddr[0], 32'h0);
    chk("grant1", gaddr[1], 32'h4);
    chk("grant2", gaddr[2], 32'h8);
    chk("first_v", dvalid, 1);
    chk("first_pc4", dpc4, 32'h4);
    repeat (4) tick();

    // stall: ID holds, queue fills, request drops, then drains in order
    nostall = 1'b0;
    repeat (6) tick();
    chk("stall_req_off", s_req, 0);
    chk("stall_v", dvalid, 1);
    nostall = 1'b1;
    acc0 = accepted;
    repeat (8) tick();
    chk("stall_drain", (accepted - acc0) >= 6, 1);

    // branch with two requests in flight
    start_reset();
    tick();
    clrn = 1'b1;
    lat_min = 3; lat_max = 3;
    wait_pc4("br_reach", 32'h10);
    chk("br_outst", p_due.size(), 2);
    pcsource = PCSRC_BR; bpc = 32'h100;
    exp_pc4 = 32'h104;
    ng = gaddr.size();
    tick();
    pcsource = PCSRC_SEQ;
    chk("br_noreq", s_req, 0);
    chk("br_bubble_v", dvalid, 0);
    chk("br_bubble_inst", inst, NOP);
    wait_grant("br_target", ng, 32'h100);
    wait_dvalid("br_resume");
    chk("br_first_pc4", dpc4, 32'h104);

    // register jump while a response arrives in the same cycle
    start_reset();
    tick();
    clrn = 1'b1;
    lat_min = 2; lat_max = 2;
    wait_pc4("jr_reach", 32'h8);
    chk("jr_outst", p_due.size(), 2);
    chk("jr_rsp_now", (p_due.size() > 0) && (p_due[0] == cyc), 1);
    pcsource = PCSRC_JR; rpc = 32'h200;
    exp_pc4 = 32'h204;
    ng = gaddr.size();
    tick();
    pcsource = PCSRC_SEQ;
    chk("jr_bubble_v", dvalid, 0);
    wait_grant("jr_target", ng, 32'h200);
    wait_dvalid("jr_resume");
    chk("jr_first_pc4", dpc4, 32'h204);

    // jump ignored under stall; unaligned target gets its low bits cleared
    nostall = 1'b0; pcsource = PCSRC_J; jpc = 32'h303;
    repeat (2) tick();
    pcsource = PCSRC_SEQ; nostall = 1'b1;
    tick();
    wait_dvalid("j_ready");
    pcsource = PCSRC_J;
    exp_pc4 = 32'h304;
    ng = gaddr.size();
    tick();
    pcsource = PCSRC_SEQ;
    wait_grant("j_target", ng, 32'h300);
    wait_dvalid("j_resume");
    chk("j_first_pc4", dpc4, 32'h304);

    // random grant and latency 1..5, random stalls
    start_reset();
    tick();
    clrn = 1'b1;
    lat_min = 1; lat_max = 5;
    rnd_gnt = 1; max_out = 0;
    acc0 = accepted;
    repeat (300) begin
      nostall = ($urandom_range(0, 3) != 0);
      tick();
    end
    rnd_gnt = 0; imem_gnt = 1'b1; nostall = 1'b1;
    chk("rnd_max_outst", max_out <= 2, 1);
    chk("rnd_progress", (accepted - acc0) > 20, 1);

    // reset with a full queue
    lat_min = 1; lat_max = 1;
    nostall = 1'b0;
    repeat (6) tick();
    nostall = 1'b1;
    start_reset();
    tick();
    chk("mid_rst_req", s_req, 0);
    chk("mid_rst_v", dvalid, 0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_pc4", dpc4, 32'h0);
    tick();
    chk("mid_rst_req2", s_req, 0);
    clrn = 1'b1;
    tick();
    chk("restart_req", s_req, 1);
    chk("restart_addr", s_addr, 32'h0);
    acc0 = accepted;
    repeat (6) tick();
    chk("restart_stream", (accepted - acc0) >= 3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
